alu_test_sequencer: RTL and testbench



---
 rtl/alu_test_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_test_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_test_sequencer.sv
// alu_test_sequencer: drives every ALU opcode over corner and LFSR-generated
// operand pairs, checks result_i against a built-in golden model, and reports
// check/mismatch counts plus a pass flag.
// Optional build macro ALU_TEST_SEQ_STOP_ON_ERR_EN: stop at the first mismatch,
// freeze the failing vector and capture the failing result on fail_result_o.
module alu_test_sequencer #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned OP_W       = 6,
   parameter int unsigned NUM_VEC    = 16,
   parameter int unsigned RESULT_LAT = 0,
   parameter logic [31:0] LFSR_SEED  = 32'h1,
   parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic [OP_W-1:0] ALUop_o,
   output logic [XLEN-1:0] operand_A_o,
   output logic [XLEN-1:0] operand_B_o,
   input  logic [XLEN-1:0] result_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic [15:0]     err_cnt_o,
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
   output logic [XLEN-1:0] fail_result_o,
`endif
   output logic [15:0]     chk_cnt_o
);

   localparam int unsigned NUM_OPS = 10;
   localparam int unsigned SH_W    = $clog2(XLEN);
   localparam int unsigned PAIR_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int unsigned WAIT_W  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
   localparam int unsigned CNT_W   = 16;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_LAST = OP_W'(NUM_OPS - 1);

   localparam logic [XLEN-1:0] MSB_ONLY = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [31:0]         lfsr_q, lfsr_d;
   logic [PAIR_W-1:0]   pair_q, pair_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [CNT_W-1:0]    err_q, err_d;
   logic [CNT_W-1:0]    chk_q, chk_d;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
   logic [XLEN-1:0]     fail_q, fail_d;
`endif
   logic                mismatch_c;
   logic                last_c;
   logic [31:0]         lfsr_s1_c;

   // Reference ALU: arithmetic modulo 2^XLEN, shift amount from low bits of B
   function automatic logic [XLEN-1:0] golden(input logic [OP_W-1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (op)
         OP_ADD:  golden = a + b;
         OP_SUB:  golden = a - b;
         OP_SLL:  golden = a << sh;
         OP_SLT:  golden = XLEN'($signed(a) < $signed(b));
         OP_SLTU: golden = XLEN'(a < b);
         OP_XOR:  golden = a ^ b;
         OP_SRL:  golden = a >> sh;
         OP_SRA:  golden = $unsigned($signed(a) >>> sh);
         OP_OR:   golden = a | b;
         OP_AND:  golden = a & b;
         default: golden = '0;
      endcase
   endfunction

   // Galois LFSR single step
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

   // Saturating counter increment
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      lfsr_d    = lfsr_q;
      pair_d    = pair_q;
      wait_d    = wait_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      chk_d     = chk_q;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
      fail_d    = fail_q;
`endif
      mismatch_c = (result_i != golden(op_q, a_q, b_q));
      last_c     = (pair_q == PAIR_W'(NUM_VEC - 1)) && (op_q == OP_LAST);
      lfsr_s1_c  = lfsr_step(lfsr_q);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_DRIVE;
               op_d    = '0;
               pair_d  = '0;
               a_d     = '0;
               b_d     = '0;
               lfsr_d  = LFSR_SEED;
               wait_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               chk_d   = '0;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
               fail_d  = '0;
`endif
            end
         end
         S_DRIVE: begin
            wait_d  = '0;
            state_d = (RESULT_LAT > 0) ? S_WAIT : S_CHECK;
         end
         S_WAIT: begin
            if (wait_q == WAIT_W'(RESULT_LAT - 1)) begin
               state_d = S_CHECK;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_CHECK: begin
            chk_d = sat_inc(chk_q);
            if (mismatch_c) begin
               err_d = sat_inc(err_q);
            end
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
            if (mismatch_c) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               fail_d  = result_i;
            end else
`endif
            if (last_c) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_DRIVE;
               if (op_q == OP_LAST) begin
                  op_d   = '0;
                  pair_d = pair_q + PAIR_W'(1);
                  if (pair_d == PAIR_W'(1)) begin
                     a_d = '1;
                     b_d = XLEN'(1);
                  end else if (pair_d == PAIR_W'(2)) begin
                     a_d = MSB_ONLY;
                     b_d = '1;
                  end else begin
                     a_d    = XLEN'(lfsr_q);
                     b_d    = XLEN'(lfsr_s1_c);
                     lfsr_d = lfsr_step(lfsr_s1_c);
                  end
               end else begin
                  op_d = op_q + OP_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lfsr_q  <= LFSR_SEED;
         pair_q  <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         chk_q   <= '0;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
         fail_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lfsr_q  <= lfsr_d;
         pair_q  <= pair_d;
         wait_q  <= wait_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         chk_q   <= chk_d;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
         fail_q  <= fail_d;
`endif
      end
   end

   assign ALUop_o     = op_q;
   assign operand_A_o = a_q;
   assign operand_B_o = b_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_cnt_o   = err_q;
   assign chk_cnt_o   = chk_q;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
   assign fail_result_o = fail_q;
`endif

endmodule

// File: tb/tb_alu_test_sequencer.sv
// tb_alu_test_sequencer: two sequencer instances (combinational and 2-cycle
// ALU stubs) checked against a bench-side operand sequence and ALU model.
module tb_alu_test_sequencer;

   localparam int NV = 4;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, start0, busy0, done0, pass0;
   logic [5:0]  op0;
   logic [31:0] a0, b0, res0, comb0, p0a, p0b;
   logic [15:0] err0, chk0;
   logic        rst2, start2, busy2, done2, pass2;
   logic [5:0]  op2;
   logic [31:0] a2, b2, res2, p2a, p2b;
   logic [15:0] err2, chk2;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
   logic [31:0] fail0, fail2;
`endif

   int   stub_mode = 0;
   logic pipe_sel  = 1'b0;

   vec_t exp_q[$];
   vec_t obs_q[$];
   int   exp_err, exp_chk, done_cyc;
   logic [15:0] st_chk;
   logic        st_done, st_busy;
   int   n_checks = 0;
   int   n_pass   = 0;

   alu_test_sequencer #(.XLEN(32), .OP_W(6), .NUM_VEC(NV), .RESULT_LAT(0)) dut0 (
      .clk_i(clk), .rst_i(rst0), .start_i(start0), .ALUop_o(op0),
      .operand_A_o(a0), .operand_B_o(b0), .result_i(res0), .busy_o(busy0),
      .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
      .fail_result_o(fail0),
`endif
      .chk_cnt_o(chk0));

   alu_test_sequencer #(.XLEN(32), .OP_W(6), .NUM_VEC(NV), .RESULT_LAT(2)) dut2 (
      .clk_i(clk), .rst_i(rst2), .start_i(start2), .ALUop_o(op2),
      .operand_A_o(a2), .operand_B_o(b2), .result_i(res2), .busy_o(busy2),
      .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
      .fail_result_o(fail2),
`endif
      .chk_cnt_o(chk2));

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ext;
      int sh;
      sh = int'(b[4:0]);
      ext = {{32{a[31]}}, a} >> sh;
      case (op)
         6'd0: ref_alu = a + b;
         6'd1: ref_alu = a - b;
         6'd2: ref_alu = a << sh;
         6'd3: ref_alu = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         6'd4: ref_alu = (a < b) ? 32'd1 : 32'd0;
         6'd5: ref_alu = a ^ b;
         6'd6: ref_alu = a >> sh;
         6'd7: ref_alu = ext[31:0];
         6'd8: ref_alu = a | b;
         6'd9: ref_alu = a & b;
         default: ref_alu = 32'd0;
      endcase
   endfunction

   // mode 1: SUB returns 0; mode 2: ADD of (all-ones, 1) corrupted
   function automatic logic [31:0] stub_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int mode);
      logic [31:0] r;
      r = ref_alu(op, a, b);
      if (mode == 1 && op == 6'd1) r = 32'd0;
      if (mode == 2 && op == 6'd0 && a == 32'hFFFF_FFFF && b == 32'd1) r = 32'hDEAD_BEEF;
      return r;
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   assign comb0 = stub_alu(op0, a0, b0, stub_mode);
   assign res0  = pipe_sel ? p0b : comb0;
   assign res2  = p2b;

   // two-stage pipelined ALU stubs
   always_ff @(posedge clk) begin
      p0a <= stub_alu(op0, a0, b0, stub_mode);
      p0b <= p0a;
      p2a <= stub_alu(op2, a2, b2, stub_mode);
      p2b <= p2a;
   end

   // expected vectors for one run plus expected check/error counts for a stub mode
   task automatic prep(input int mode);
      logic [31:0] s, a, b;
      vec_t v;
      logic stopped;
      exp_q.delete();
      s = 32'h1;
      for (int p = 0; p < NV; p++) begin
         case (p)
            0: begin a = 32'h0; b = 32'h0; end
            1: begin a = 32'hFFFF_FFFF; b = 32'h1; end
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: begin a = s; s = lfsr_next(s); b = s; s = lfsr_next(s); end
         endcase
         for (int op = 0; op < 10; op++) begin
            v.op = 6'(op); v.a = a; v.b = b; v.res = ref_alu(6'(op), a, b);
            exp_q.push_back(v);
         end
      end
      exp_err = 0; exp_chk = 0; stopped = 1'b0;
      foreach (exp_q[i]) begin
         if (!stopped) begin
            exp_chk++;
            if (stub_alu(exp_q[i].op, exp_q[i].a, exp_q[i].b, mode) != exp_q[i].res) begin
               exp_err++;
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
               stopped = 1'b1;
`endif
            end
         end
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start0 = v; else start2 = v;
   endtask

   function automatic vec_t cur(input int sel);
      vec_t v;
      if (sel == 0) begin v.op = op0; v.a = a0; v.b = b0; v.res = res0; end
      else          begin v.op = op2; v.a = a2; v.b = b2; v.res = comb0; end
      return v;
   endfunction

   // start a run, record each presented vector and the cycle done_o rises
   task automatic run_dut(input int sel, input int lat, input int pulse_at);
      int per;
      per = 2 + lat;
      obs_q.delete();
      done_cyc = -1;
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      st_chk  = (sel == 0) ? chk0 : chk2;
      st_done = (sel == 0) ? done0 : done2;
      st_busy = (sel == 0) ? busy0 : busy2;
      if (st_busy) obs_q.push_back(cur(sel));
      for (int c = 1; c <= 400; c++) begin
         if (c == pulse_at) set_start(sel, 1'b1);
         @(posedge clk); #1;
         set_start(sel, 1'b0);
         if ((sel == 0 ? done0 : done2) === 1'b1) begin
            done_cyc = c;
            break;
         end
         if ((sel == 0 ? busy0 : busy2) === 1'b1 && (c % per) == 0) obs_q.push_back(cur(sel));
      end
   endtask

   task automatic test_reset;
      rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({op0, a0, b0, busy0, done0, pass0, err0, chk0} !== '0)
         $display("FAIL reset_dut0 got op=%0d a=%h b=%h busy=%b done=%b pass=%b err=%0d chk=%0d want all 0",
                  op0, a0, b0, busy0, done0, pass0, err0, chk0);
      else n_pass++;
      n_checks++;
      if ({op2, a2, b2, busy2, done2, pass2, err2, chk2} !== '0)
         $display("FAIL reset_dut2 got op=%0d a=%h b=%h busy=%b done=%b pass=%b err=%0d chk=%0d want all 0",
                  op2, a2, b2, busy2, done2, pass2, err2, chk2);
      else n_pass++;
      @(negedge clk);
      rst0 = 1'b0; rst2 = 1'b0;
   endtask

   task automatic test_comb_pass;
      vec_t o, e;
      int k;
      stub_mode = 0; pipe_sel = 1'b0;
      prep(0);
      run_dut(0, 0, -1);
      n_checks++;
      if (done_cyc !== 2 * exp_chk) $display("FAIL comb_done_cycle got %0d want %0d", done_cyc, 2 * exp_chk);
      else n_pass++;
      n_checks++;
      if (chk0 !== 16'(exp_chk) || err0 !== 16'(exp_err) || pass0 !== 1'b1 || busy0 !== 1'b0)
         $display("FAIL comb_final got chk=%0d err=%0d pass=%b busy=%b want chk=%0d err=%0d pass=1 busy=0",
                  chk0, err0, pass0, busy0, exp_chk, exp_err);
      else n_pass++;
      if (obs_q.size() > 21) begin
         o = obs_q[21];
         n_checks++;
         if (o.op !== 6'd1 || o.a !== 32'h8000_0000 || o.b !== 32'hFFFF_FFFF || o.res !== 32'h8000_0001)
            $display("FAIL pair2_sub got op=%0d a=%h b=%h res=%h want op=1 a=80000000 b=ffffffff res=80000001",
                     o.op, o.a, o.b, o.res);
         else n_pass++;
      end
      n_checks++;
      if (obs_q.size() !== exp_chk) $display("FAIL comb_vec_count got %0d want %0d", obs_q.size(), exp_chk);
      else n_pass++;
      k = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if ({o.op, o.a, o.b} !== {e.op, e.a, e.b})
            $display("FAIL comb_vec[%0d] got op=%0d a=%h b=%h want op=%0d a=%h b=%h", k, o.op, o.a, o.b, e.op, e.a, e.b);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_sub_fault;
      vec_t o, e;
      int k;
      stub_mode = 1; pipe_sel = 1'b0;
      prep(1);
      run_dut(0, 0, -1);
      n_checks++;
      if (chk0 !== 16'(exp_chk) || err0 !== 16'(exp_err) || pass0 !== 1'b0 || done0 !== 1'b1)
         $display("FAIL sub_fault_final got chk=%0d err=%0d pass=%b done=%b want chk=%0d err=%0d pass=0 done=1",
                  chk0, err0, pass0, done0, exp_chk, exp_err);
      else n_pass++;
      n_checks++;
      if (obs_q.size() !== exp_chk) $display("FAIL sub_vec_count got %0d want %0d", obs_q.size(), exp_chk);
      else n_pass++;
      k = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if ({o.op, o.a, o.b} !== {e.op, e.a, e.b})
            $display("FAIL sub_vec[%0d] got op=%0d a=%h b=%h want op=%0d a=%h b=%h", k, o.op, o.a, o.b, e.op, e.a, e.b);
         else n_pass++;
         k++;
      end
      stub_mode = 0;
   endtask

   task automatic test_pipelined;
      vec_t o, e;
      int k;
      stub_mode = 0;
      prep(0);
      run_dut(2, 2, -1);
      n_checks++;
      if (done_cyc !== 4 * exp_chk) $display("FAIL pipe_done_cycle got %0d want %0d", done_cyc, 4 * exp_chk);
      else n_pass++;
      n_checks++;
      if (chk2 !== 16'(exp_chk) || err2 !== 16'd0 || pass2 !== 1'b1)
         $display("FAIL pipe_final got chk=%0d err=%0d pass=%b want chk=%0d err=0 pass=1", chk2, err2, pass2, exp_chk);
      else n_pass++;
      k = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if ({o.op, o.a, o.b} !== {e.op, e.a, e.b})
            $display("FAIL pipe_vec[%0d] got op=%0d a=%h b=%h want op=%0d a=%h b=%h", k, o.op, o.a, o.b, e.op, e.a, e.b);
         else n_pass++;
         k++;
      end
      pipe_sel = 1'b1;
      run_dut(0, 0, -1);
      n_checks++;
      if (err0 === 16'd0 || pass0 !== 1'b0 || done0 !== 1'b1)
         $display("FAIL lat_mismatch got err=%0d pass=%b done=%b want err>0 pass=0 done=1", err0, pass0, done0);
      else n_pass++;
      pipe_sel = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      vec_t o, e;
      int k;
      stub_mode = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      n_checks++;
      if (busy2 !== 1'b1 || chk2 !== 16'd5) $display("FAIL midrun_state got busy=%b chk=%0d want busy=1 chk=5", busy2, chk2);
      else n_pass++;
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      n_checks++;
      if ({op2, a2, b2, busy2, done2, pass2, err2, chk2} !== '0)
         $display("FAIL midrun_reset got op=%0d a=%h b=%h busy=%b done=%b pass=%b err=%0d chk=%0d want all 0",
                  op2, a2, b2, busy2, done2, pass2, err2, chk2);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0 || chk2 !== 16'd0)
         $display("FAIL post_reset_idle got busy=%b done=%b chk=%0d want 0 0 0", busy2, done2, chk2);
      else n_pass++;
      prep(0);
      run_dut(2, 2, -1);
      n_checks++;
      if (done_cyc !== 4 * exp_chk || chk2 !== 16'(exp_chk) || err2 !== 16'd0 || pass2 !== 1'b1)
         $display("FAIL rerun_after_reset got cyc=%0d chk=%0d err=%0d pass=%b want cyc=%0d chk=%0d err=0 pass=1",
                  done_cyc, chk2, err2, pass2, 4 * exp_chk, exp_chk);
      else n_pass++;
      k = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if ({o.op, o.a, o.b} !== {e.op, e.a, e.b})
            $display("FAIL rerun_vec[%0d] got op=%0d a=%h b=%h want op=%0d a=%h b=%h", k, o.op, o.a, o.b, e.op, e.a, e.b);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_back_to_back;
      vec_t o, e;
      int k;
      stub_mode = 0; pipe_sel = 1'b0;
      for (int r = 0; r < 2; r++) begin
         prep(0);
         run_dut(0, 0, (r == 0) ? 30 : -1);
         n_checks++;
         if (st_chk !== 16'd0 || st_done !== 1'b0 || st_busy !== 1'b1)
            $display("FAIL b2b_start[%0d] got chk=%0d done=%b busy=%b want chk=0 done=0 busy=1", r, st_chk, st_done, st_busy);
         else n_pass++;
         n_checks++;
         if (done_cyc !== 2 * exp_chk || chk0 !== 16'(exp_chk) || err0 !== 16'd0 || pass0 !== 1'b1)
            $display("FAIL b2b_final[%0d] got cyc=%0d chk=%0d err=%0d pass=%b want cyc=%0d chk=%0d err=0 pass=1",
                     r, done_cyc, chk0, err0, pass0, 2 * exp_chk, exp_chk);
         else n_pass++;
         k = 0;
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if ({o.op, o.a, o.b} !== {e.op, e.a, e.b})
               $display("FAIL b2b_vec[%0d] got op=%0d a=%h b=%h want op=%0d a=%h b=%h", k, o.op, o.a, o.b, e.op, e.a, e.b);
            else n_pass++;
            k++;
         end
      end
   endtask

`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
   task automatic test_stop_on_err;
      stub_mode = 2; pipe_sel = 1'b0;
      prep(2);
      run_dut(0, 0, -1);
      n_checks++;
      if (done_cyc !== 22 || chk0 !== 16'd11 || err0 !== 16'd1 || pass0 !== 1'b0)
         $display("FAIL stop_final got cyc=%0d chk=%0d err=%0d pass=%b want cyc=22 chk=11 err=1 pass=0",
                  done_cyc, chk0, err0, pass0);
      else n_pass++;
      n_checks++;
      if (op0 !== 6'd0 || a0 !== 32'hFFFF_FFFF || b0 !== 32'd1 || fail0 !== 32'hDEAD_BEEF)
         $display("FAIL stop_frozen got op=%0d a=%h b=%h fail=%h want op=0 a=ffffffff b=1 fail=deadbeef",
                  op0, a0, b0, fail0);
      else n_pass++;
      n_checks++;
      if (chk0 !== 16'(exp_chk)) $display("FAIL stop_model_chk got %0d want %0d", chk0, exp_chk);
      else n_pass++;
      stub_mode = 0;
      prep(0);
      run_dut(0, 0, -1);
      n_checks++;
      if (fail0 !== 32'd0 || pass0 !== 1'b1)
         $display("FAIL stop_clean_rerun got fail=%h pass=%b want fail=0 pass=1", fail0, pass0);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_comb_pass();
      test_sub_fault();
      test_pipelined();
      test_reset_mid_run();
      test_back_to_back();
`ifdef ALU_TEST_SEQ_STOP_ON_ERR_EN
      test_stop_on_err();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
